// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: access-size codes, FSM states and
// grant-owner tags.
package synapse_mem_pkg;

    // d_size encodings; 2'b11 is reserved and rejected as misaligned
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } arb_state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of the arbiter.
//
// Handshake: a requester raises *_req with its address/controls stable and
// keeps them stable until it sees the one-cycle *_ack; response data is only
// meaningful in the ack cycle. Memory enables are one-cycle strobes and
// mem_rdata must be valid MEM_LAT cycles after the read strobe.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_misalign;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata, d_misalign,
               mem_addr, mem_wdata, mem_wstrb, mem_rd_en, mem_wr_en
    );

    // Core + memory side
    modport master (
        output if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata, d_misalign,
               mem_addr, mem_wdata, mem_wstrb, mem_rd_en, mem_wr_en
    );
endinterface

// File: rtl/mem_arbiter_lane_align.sv
// Byte-lane steering for data accesses: store strobes and data replication,
// load lane select with sign/zero extension, and misalignment detection.
module mem_lane_align
    import synapse_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Decode lanes and extension from size and the low address bits
    always_comb begin
        wstrb_o    = 4'b0000;
        wdata_o    = 32'h0;
        load_o     = 32'h0;
        misalign_o = 1'b0;
        byte_sel   = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (size_i)
            SIZE_B: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                load_o  = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                misalign_o = addr_lo_i[0];
                wstrb_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o    = {2{wdata_i[15:0]}};
                load_o     = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            SIZE_W: begin
                misalign_o = |addr_lo_i;
                wstrb_o    = 4'b1111;
                wdata_o    = wdata_i;
                load_o     = rdata_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and load/store,
// sequencing each access over a fixed memory latency with registered outputs.
module mem_arbiter
    import synapse_mem_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output arb_state_e    dbg_state_o
);

    // WAIT lasts MEM_LAT-1 cycles; with MEM_LAT=1 it is skipped entirely
    localparam logic [2:0] CNT_INIT = 3'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    arb_state_e  state_q;
    gnt_e        owner_q, last_q, grant_d;
    logic [2:0]  cnt_q;
    logic        if_ack_q, d_ack_q, d_misalign_q;
    logic [31:0] if_rdata_q, d_rdata_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic        mem_rd_en_q, mem_wr_en_q;

    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata, al_load;
    logic        al_misalign;

    mem_lane_align u_align (
        .size_i     (bus.d_size),
        .addr_lo_i  (bus.d_addr[1:0]),
        .unsigned_i (bus.d_unsigned),
        .wdata_i    (bus.d_wdata),
        .rdata_i    (bus.mem_rdata),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .load_o     (al_load),
        .misalign_o (al_misalign)
    );

    // Pick the requester: a lone request wins, a tie goes to the one not granted last
    always_comb begin
        grant_d = GNT_IF;
        if (bus.d_req && (!bus.if_req || last_q == GNT_IF)) grant_d = GNT_D;
    end

    // Access sequencer with registered memory-side and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= GNT_IF;
            last_q       <= GNT_IF;
            cnt_q        <= 3'd0;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            d_misalign_q <= 1'b0;
            if_rdata_q   <= 32'h0;
            d_rdata_q    <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wstrb_q  <= 4'h0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
        end else begin
            // Strobes and memory-side fields are single-cycle by default
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            d_misalign_q <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_wstrb_q  <= 4'h0;
            mem_rd_en_q  <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        last_q  <= grant_d;
                        owner_q <= grant_d;
                        if (grant_d == GNT_D) begin
                            if (al_misalign) begin
                                // Rejected access: straight to the response, memory untouched
                                state_q      <= ST_RESP;
                                d_ack_q      <= 1'b1;
                                d_misalign_q <= 1'b1;
                                d_rdata_q    <= 32'h0;
                            end else begin
                                state_q     <= ST_ISSUE;
                                mem_addr_q  <= {bus.d_addr[31:2], 2'b00};
                                mem_rd_en_q <= !bus.d_we;
                                mem_wr_en_q <= bus.d_we;
                                // Strobes and data are only driven for stores
                                mem_wstrb_q <= bus.d_we ? al_wstrb : 4'h0;
                                mem_wdata_q <= bus.d_we ? al_wdata : 32'h0;
                            end
                        end else begin
                            state_q     <= ST_ISSUE;
                            mem_addr_q  <= {bus.if_addr[31:2], 2'b00};
                            mem_rd_en_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= CNT_INIT;
                    state_q <= (MEM_LAT == 1) ? ST_CAPTURE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q == 3'd0) state_q <= ST_CAPTURE;
                    else               cnt_q   <= cnt_q - 3'd1;
                end
                ST_CAPTURE: begin
                    state_q <= ST_RESP;
                    if (owner_q == GNT_IF) begin
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= bus.mem_rdata;
                    end else begin
                        d_ack_q   <= 1'b1;
                        d_rdata_q <= bus.d_we ? 32'h0 : al_load;
                    end
                end
                ST_RESP: begin
                    state_q    <= ST_IDLE;
                    if_rdata_q <= 32'h0;
                    d_rdata_q  <= 32'h0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.if_ack     = if_ack_q;
    assign bus.if_rdata   = if_rdata_q;
    assign bus.d_ack      = d_ack_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.d_misalign = d_misalign_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
    assign bus.mem_rd_en  = mem_rd_en_q;
    assign bus.mem_wr_en  = mem_wr_en_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a cycle-schedule reference model for the MEM_LAT=1
// instance, directed literal checks, randomized traffic, and a MEM_LAT=3
// instance used for the reset-abort scenario.
module tb_mem_arbiter;
    import synapse_mem_pkg::*;

    localparam int LAT = 1;

    typedef struct packed {
        logic        if_ack;
        logic [31:0] if_rdata;
        logic        d_ack;
        logic [31:0] d_rdata;
        logic        d_misalign;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
        logic        mem_rd_en;
        logic        mem_wr_en;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    arb_state_e dbg, dbg2;

    mem_arbiter_if bus();
    mem_arbiter_if b2();

    mem_arbiter #(.MEM_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg));
    mem_arbiter #(.MEM_LAT(3)) dut2 (.clk(clk), .rst(rst2), .bus(b2), .dbg_state_o(dbg2));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // ---------------- memory (DUT side) and shadow (model side) ----------------
    logic [31:0] dmem[16];
    logic [31:0] smem[16];
    int rd_due[int];

    // ---------------- reference model state ----------------
    out_t sched[int];
    int   free_at = 0;
    bit   last_d = 1'b0;
    bit   model_on = 1'b0;

    // monitor records
    int          en_cnt = 0;
    logic [31:0] last_maddr, last_wdata;
    logic [3:0]  last_wstrb;
    int          ack_log[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [31:0] v);
        dmem[i] = v;
        smem[i] = v;
    endtask

    // Model: a transaction granted at edge k owns the port until edge k+LAT+3
    // (k+2 when rejected); outputs are scheduled per cycle from access rules.
    task automatic model_step(input int e);
        out_t o;
        int   keys[$];
        int   idx, off, n;
        logic [31:0] w, v, a;
        bit   gd, mis;
        if (rst) begin
            foreach (sched[k]) if (k > e) keys.push_back(k);
            foreach (keys[j]) sched.delete(keys[j]);
            free_at  = e + 1;
            last_d   = 1'b0;
            model_on = 1'b1;
            return;
        end
        if (!model_on || e < free_at) return;
        if (!bus.if_req && !bus.d_req) return;
        gd = bus.d_req && (!bus.if_req || !last_d);
        last_d = gd;
        if (!gd) begin
            a = bus.if_addr;
            o = '0; o.mem_rd_en = 1'b1; o.mem_addr = a & 32'hFFFF_FFFC;
            sched[e + 1] = o;
            o = '0; o.if_ack = 1'b1; o.if_rdata = smem[a[5:2]];
            sched[e + 2 + LAT] = o;
            free_at = e + 3 + LAT;
            return;
        end
        a   = bus.d_addr;
        off = int'(a % 4);
        n   = (bus.d_size == 2'd0) ? 1 : (bus.d_size == 2'd1) ? 2 : 4;
        mis = (bus.d_size == 2'd3) || (off % n != 0);
        if (mis) begin
            o = '0; o.d_ack = 1'b1; o.d_misalign = 1'b1;
            sched[e + 1] = o;
            free_at = e + 2;
            return;
        end
        idx = int'(a[5:2]);
        o = '0;
        o.mem_addr = a & 32'hFFFF_FFFC;
        if (bus.d_we) begin
            o.mem_wr_en = 1'b1;
            w = bus.d_wdata;
            for (int i = 0; i < 4; i++) begin
                o.mem_wdata[8*i +: 8] = 8'(w >> (8 * (i % n)));
                if (i >= off && i < off + n) begin
                    o.mem_wstrb[i] = 1'b1;
                    smem[idx][8*i +: 8] = 8'(w >> (8 * (i - off)));
                end
            end
            sched[e + 1] = o;
            o = '0; o.d_ack = 1'b1; o.d_rdata = 32'h0;
        end else begin
            o.mem_rd_en = 1'b1;
            sched[e + 1] = o;
            v = smem[idx] >> (8 * off);
            if (n == 1) v = bus.d_unsigned ? (v & 32'hFF) : ((v & 32'hFF) ^ 32'h80) - 32'h80;
            if (n == 2) v = bus.d_unsigned ? (v & 32'hFFFF) : ((v & 32'hFFFF) ^ 32'h8000) - 32'h8000;
            o = '0; o.d_ack = 1'b1; o.d_rdata = v;
        end
        sched[e + 2 + LAT] = o;
        free_at = e + 3 + LAT;
    endtask

    // model steps on every rising edge, then the cycle index advances
    initial forever begin
        @(posedge clk);
        model_step(cyc);
        cyc++;
    end

    // memory: returns read data exactly LAT cycles after the strobe, junk otherwise
    initial forever begin
        @(posedge clk);
        #1;
        if (rd_due.exists(cyc)) begin
            bus.mem_rdata = dmem[rd_due[cyc]];
            rd_due.delete(cyc);
        end else begin
            bus.mem_rdata = $urandom;
        end
    end

    // ---------------- scoreboard compare + monitor ----------------
    initial forever begin
        out_t exp, act;
        @(negedge clk);
        act.if_ack = bus.if_ack;       act.if_rdata = bus.if_rdata;
        act.d_ack = bus.d_ack;         act.d_rdata = bus.d_rdata;
        act.d_misalign = bus.d_misalign;
        act.mem_addr = bus.mem_addr;   act.mem_wdata = bus.mem_wdata;
        act.mem_wstrb = bus.mem_wstrb; act.mem_rd_en = bus.mem_rd_en;
        act.mem_wr_en = bus.mem_wr_en;
        if (model_on) begin
            exp = sched.exists(cyc) ? sched[cyc] : '0;
            sched.delete(cyc);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL cycle %0d outputs act=%h exp=%h", cyc, act, exp);
            end
        end
        if (bus.mem_rd_en || bus.mem_wr_en) begin
            en_cnt++;
            last_maddr = bus.mem_addr;
            last_wdata = bus.mem_wdata;
            last_wstrb = bus.mem_wstrb;
        end
        if (bus.mem_rd_en) rd_due[cyc + LAT] = int'(bus.mem_addr[5:2]);
        if (bus.mem_wr_en)
            for (int i = 0; i < 4; i++)
                if (bus.mem_wstrb[i]) dmem[bus.mem_addr[5:2]][8*i +: 8] = bus.mem_wdata[8*i +: 8];
        if (bus.if_ack) ack_log.push_back(0);
        if (bus.d_ack)  ack_log.push_back(1);
    end

    // ---------------- driver tasks (called at posedge+#1) ----------------
    task automatic do_data(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic mis, output int lat);
        int s;
        bit got;
        bus.d_we = we; bus.d_size = sz; bus.d_unsigned = uns;
        bus.d_addr = addr; bus.d_wdata = wd; bus.d_req = 1'b1;
        s = cyc; got = 1'b0; rd = '0; mis = 1'b0; lat = -1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (bus.d_ack) begin
                got = 1'b1; rd = bus.d_rdata; mis = bus.d_misalign; lat = cyc - s;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL d_ack_timeout act=none exp=ack");
        end
        @(posedge clk);
        #1;
        bus.d_req = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] addr, output logic [31:0] rd, output int lat);
        int s;
        bit got;
        bus.if_addr = addr; bus.if_req = 1'b1;
        s = cyc; got = 1'b0; rd = '0; lat = -1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            if (bus.if_ack) begin
                got = 1'b1; rd = bus.if_rdata; lat = cyc - s;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL if_ack_timeout act=none exp=ack");
        end
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        logic mis;
        int lat, en0;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_size = 0;
        bus.d_unsigned = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
        b2.if_req = 0; b2.if_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_size = 0;
        b2.d_unsigned = 0; b2.d_addr = 0; b2.d_wdata = 0; b2.mem_rdata = 32'h0000_0013;
        for (int i = 0; i < 16; i++) set_word(i, $urandom);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check32("reset_d_ack", {31'h0, bus.d_ack}, 32'h0);
        check32("reset_mem_addr", bus.mem_addr, 32'h0);
        @(posedge clk);
        #1;

        // signed / unsigned byte load
        set_word(0, 32'h8000_0000);
        do_data(1'b0, SIZE_B, 1'b0, 32'h0000_0103, 32'h0, rd, mis, lat);
        check32("lb_rdata", rd, 32'hFFFF_FF80);
        check32("lb_latency", lat, 3);
        check32("lb_mem_addr", last_maddr, 32'h0000_0100);
        do_data(1'b0, SIZE_B, 1'b1, 32'h0000_0103, 32'h0, rd, mis, lat);
        check32("lbu_rdata", rd, 32'h0000_0080);

        // half store
        en0 = en_cnt;
        do_data(1'b1, SIZE_H, 1'b0, 32'h0000_0202, 32'h0000_BEEF, rd, mis, lat);
        check32("sh_rdata", rd, 32'h0);
        check32("sh_wstrb", {28'h0, last_wstrb}, 32'hC);
        check32("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        check32("sh_mem_addr", last_maddr, 32'h0000_0200);
        check32("sh_one_strobe", en_cnt - en0, 1);

        // misaligned word
        en0 = en_cnt;
        do_data(1'b0, SIZE_W, 1'b0, 32'h0000_0006, 32'h0, rd, mis, lat);
        check32("lw_mis_flag", {31'h0, mis}, 32'h1);
        check32("lw_mis_latency", lat, 1);
        check32("lw_mis_no_enable", en_cnt - en0, 0);

        // unaligned fetch
        set_word(4, 32'h0000_0013);
        do_fetch(32'h0000_0013, rd, lat);
        check32("fetch_rdata", rd, 32'h0000_0013);
        check32("fetch_mem_addr", last_maddr, 32'h0000_0010);
        check32("fetch_wstrb", {28'h0, last_wstrb}, 32'h0);
        check32("fetch_latency", lat, 3);

        // reset, then both requesters raised together
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ack_log.delete();
        fork
            begin
                logic [31:0] r; int l;
                do_fetch(32'h0000_0020, r, l);
                do_fetch(32'h0000_0024, r, l);
            end
            begin
                logic [31:0] r; logic m; int l;
                do_data(1'b0, SIZE_W, 1'b0, 32'h0000_0030, 32'h0, r, m, l);
                do_data(1'b0, SIZE_W, 1'b0, 32'h0000_0034, 32'h0, r, m, l);
            end
        join
        check32("tie_count", ack_log.size(), 4);
        if (ack_log.size() == 4) begin
            check32("tie_order0", ack_log[0], 1);
            check32("tie_order1", ack_log[1], 0);
            check32("tie_order2", ack_log[2], 1);
            check32("tie_order3", ack_log[3], 0);
        end

        // randomized concurrent traffic
        fork
            begin
                logic [31:0] r; int l;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    do_fetch($urandom, r, l);
                end
            end
            begin
                logic [31:0] r; logic m; int l;
                for (int i = 0; i < 50; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    do_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            1'($urandom_range(0, 1)), $urandom, $urandom, r, m, l);
                end
            end
        join

        // reset during WAIT on the MEM_LAT=3 instance
        begin
            int s, f, acks;
            bit got;
            rst2 = 1'b0;
            @(posedge clk);
            #1;
            b2.d_we = 1'b0; b2.d_size = SIZE_W; b2.d_addr = 32'h0000_0040; b2.d_req = 1'b1;
            s = cyc;
            @(negedge clk);
            @(negedge clk);
            check32("l3_issue_rd_en", {31'h0, b2.mem_rd_en}, 32'h1);
            @(negedge clk);
            check32("l3_in_wait", 32'(dbg2), 32'(ST_WAIT));
            check32("l3_wait_cycle", cyc - s, 2);
            rst2 = 1'b1;
            b2.d_req = 1'b0;
            @(posedge clk);
            #1;
            rst2 = 1'b0;
            @(negedge clk);
            check32("l3_reset_outputs",
                    {b2.if_ack, b2.d_ack, b2.d_misalign, b2.mem_rd_en, b2.mem_wr_en,
                     b2.mem_wstrb, b2.mem_addr | b2.mem_wdata | b2.if_rdata | b2.d_rdata}, 32'h0);
            check32("l3_reset_state", 32'(dbg2), 32'(ST_IDLE));
            acks = 0;
            repeat (6) begin
                @(negedge clk);
                if (b2.d_ack || b2.if_ack) acks++;
            end
            check32("l3_no_ack_after_reset", acks, 0);
            @(posedge clk);
            #1;
            b2.if_addr = 32'h0000_0013; b2.if_req = 1'b1;
            f = cyc; got = 1'b0;
            for (int n = 0; n < 32 && !got; n++) begin
                @(negedge clk);
                if (b2.if_ack) begin
                    got = 1'b1;
                    check32("l3_fetch_latency", cyc - f, 5);
                    check32("l3_fetch_rdata", b2.if_rdata, 32'h0000_0013);
                end
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL l3_fetch_timeout act=none exp=ack");
            end
            @(posedge clk);
            #1;
            b2.if_req = 1'b0;
        end

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog act=running exp=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
